overlay_value_ctrl: RTL and testbench

- Owns the 12-bit values shown by the hex text overlay. Replaces direct sampling of ADC buses during vsync.
- Arbitrates two writers, for example the ADC capture logic and a debug/command port, into a shadow register bank.
- Commits the shadow bank to the active bank at the start of vertical sync, so displayed digits never tear mid-frame.
- The font/overlay path reads the active bank by index.

---
 rtl/video_pkg.sv | 21 ++
 rtl/overlay_value_ctrl_rr_arb2.sv | 46 ++++
 rtl/overlay_value_ctrl.sv | 166 ++++++++++++++++
 tb/tb_overlay_value_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// ============================================================================
// Module : video_pkg
// Brief  : Shared overlay types and sizing constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package video_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } ovl_state_t;

  localparam int OVL_DATA_W     = 12;
  localparam int OVL_NUM_VALUES = 5;

endpackage

`default_nettype wire

// File: rtl/overlay_value_ctrl_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter; pointer flips only on contended grants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr_q == 0 favours requester 0 when both are valid
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      if (valid == 2'b11) begin
        grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
    if (advance) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/overlay_value_ctrl.sv
// ============================================================================
// Module : overlay_value_ctrl
// Brief  : Shadow/active value banks for the hex overlay, committed on vsync.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module overlay_value_ctrl
  import video_pkg::*;
#(
  parameter int NUM_VALUES = OVL_NUM_VALUES,
  parameter int DATA_W     = OVL_DATA_W,
  parameter int IDX_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              req0_valid,
  input  logic [IDX_W-1:0]  req0_index,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [IDX_W-1:0]  req1_index,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              pending,
  output logic              commit_done,
  output logic              bad_index
);

  localparam logic [IDX_W:0]   NUM_V    = (IDX_W+1)'(NUM_VALUES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

  ovl_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q [NUM_VALUES];
  logic [DATA_W-1:0] shadow_d [NUM_VALUES];
  logic [DATA_W-1:0] active_q [NUM_VALUES];
  logic [DATA_W-1:0] active_d [NUM_VALUES];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              vsync_q;
  logic              pending_q, pending_d;
  logic              commit_done_q, commit_done_d;
  logic              bad_index_q, bad_index_d;

  logic              accept_en;
  logic [1:0]        grant;
  logic              advance;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              wr_in_range;
  logic              vsync_rise;

  assign accept_en   = (state_q == IDLE) || (state_q == PENDING);
  assign advance     = accept_en && req0_valid && req1_valid;
  assign wr_en       = |grant;
  assign wr_idx      = grant[1] ? req1_index : req0_index;
  assign wr_data     = grant[1] ? req1_data  : req0_data;
  assign wr_in_range = ({1'b0, wr_idx} < NUM_V);
  assign vsync_rise  = vsync && !vsync_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (accept_en),
    .valid   ({req1_valid, req0_valid}),
    .advance (advance),
    .grant   (grant)
  );

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rd_data     = rd_data_q;
  assign pending     = pending_q;
  assign commit_done = commit_done_q;
  assign bad_index   = bad_index_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_done_d = 1'b0;
    bad_index_d   = wr_en && !wr_in_range;

    // A write landing on the vsync_rise edge is already in shadow when COMMIT copies
    for (int i = 0; i < NUM_VALUES; i++) begin
      if (wr_en && wr_in_range && (wr_idx == IDX_W'(i))) begin
        shadow_d[i] = wr_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (wr_en && wr_in_range) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vsync_rise) begin
          state_d = COMMIT;
          cnt_d   = '0;
        end
      end
      COMMIT: begin
        for (int i = 0; i < NUM_VALUES; i++) begin
          if (cnt_q == IDX_W'(i)) begin
            active_d[i] = shadow_q[i];
          end
        end
        if (cnt_q == LAST_IDX) begin
          state_d       = IDLE;
          commit_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = (state_d == PENDING);

    rd_data_d = '0;
    for (int i = 0; i < NUM_VALUES; i++) begin
      if (rd_index == IDX_W'(i)) begin
        rd_data_d = active_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_data_q     <= '0;
      vsync_q       <= 1'b0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      bad_index_q   <= 1'b0;
      for (int i = 0; i < NUM_VALUES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      vsync_q       <= vsync;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      bad_index_q   <= bad_index_d;
      for (int i = 0; i < NUM_VALUES; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_overlay_value_ctrl.sv
// ============================================================================
// Module : tb_overlay_value_ctrl
// Brief  : Self-checking bench for overlay_value_ctrl with a read scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_overlay_value_ctrl;
  import video_pkg::*;

  localparam int NV = OVL_NUM_VALUES;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vsync = 1'b0;
  logic        req0_valid = 1'b0;
  logic [2:0]  req0_index = '0;
  logic [11:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [2:0]  req1_index = '0;
  logic [11:0] req1_data = '0;
  logic        req1_ready;
  logic [2:0]  rd_index = '0;
  logic [11:0] rd_data;
  logic        pending;
  logic        commit_done;
  logic        bad_index;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q [$];
  logic        rd_track = 1'b0;
  logic [11:0] m_shadow [NV];
  logic [11:0] m_active [NV];

  overlay_value_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .req0_valid  (req0_valid),
    .req0_index  (req0_index),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_index  (req1_index),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .pending     (pending),
    .commit_done (commit_done),
    .bad_index   (bad_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read data appears one edge after the index is presented
  always @(posedge clk) begin : mon
    logic trk;
    trk = rd_track;
    #1;
    if (trk) begin
      chk("sb_depth", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic rd(input int idx);
    rd_index = 3'(idx);
    if (idx < NV) exp_q.push_back(m_active[idx]);
    else          exp_q.push_back(12'h000);
    rd_track = 1'b1;
    tick();
    rd_track = 1'b0;
  endtask

  // Called one cycle after the vsync_rise edge; ends in the commit_done cycle
  task automatic commit_tail(input bit hold_r1);
    if (hold_r1) begin
      req1_valid = 1'b1;
      req1_index = 3'd3;
      req1_data  = 12'h555;
    end
    for (int n = 1; n <= 6; n++) begin
      #1;
      chk("commit_done", 32'(commit_done), 32'(n == 6));
      if (n <= 5) begin
        chk("commit_rdy0", 32'(req0_ready), 32'd0);
        chk("commit_rdy1", 32'(req1_ready), 32'd0);
      end
      if (n < 6) tick();
    end
    m_active = m_shadow;
    vsync = 1'b0;
    if (hold_r1) begin
      chk("stall_accept", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      m_shadow[3] = 12'h555;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int g0;
    int g1;
    for (int i = 0; i < NV; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end

    // Reset
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_commit_done", 32'(commit_done), 32'd0);
    chk("rst_bad_index", 32'(bad_index), 32'd0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < NV; i++) rd(i);
    chk("post_rst_pending", 32'(pending), 32'd0);

    // Basic commit
    req0_valid = 1'b1; req0_index = 3'd2; req0_data = 12'hABC;
    #1;
    chk("basic_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    m_shadow[2] = 12'hABC;
    chk("basic_pending", 32'(pending), 32'd1);
    rd(2);
    chk("basic_pending_hold", 32'(pending), 32'd1);
    vsync = 1'b1;
    tick();
    commit_tail(1'b0);
    tick();
    chk("basic_pending_clr", 32'(pending), 32'd0);
    rd(2);

    // Contention: grants alternate starting from requester 0
    g0 = 0; g1 = 0;
    req0_valid = 1'b1; req0_index = 3'd0; req0_data = 12'h001;
    req1_valid = 1'b1; req1_index = 3'd1; req1_data = 12'h002;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_rdy0", 32'(req0_ready), 32'((k % 2) == 0));
      chk("cont_rdy1", 32'(req1_ready), 32'((k % 2) == 1));
      g0 += int'(req0_ready);
      g1 += int'(req1_ready);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_shadow[0] = 12'h001;
    m_shadow[1] = 12'h002;
    chk("cont_g0", 32'(g0), 32'd2);
    chk("cont_g1", 32'(g1), 32'd2);

    // Stall during commit: req1 held across COMMIT, lands in the next frame
    vsync = 1'b1;
    tick();
    commit_tail(1'b1);
    chk("stall_pending", 32'(pending), 32'd1);
    rd(3);
    rd(0);
    rd(1);
    vsync = 1'b1;
    tick();
    commit_tail(1'b0);
    tick();
    rd(3);

    // vsync in IDLE is ignored
    vsync = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("idle_vs_done", 32'(commit_done), 32'd0);
      chk("idle_vs_pend", 32'(pending), 32'd0);
    end
    vsync = 1'b0;

    // Bad index
    req0_valid = 1'b1; req0_index = 3'd7; req0_data = 12'h123;
    #1;
    chk("bad_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("bad_pulse", 32'(bad_index), 32'd1);
    chk("bad_pending", 32'(pending), 32'd0);
    tick();
    chk("bad_pulse_end", 32'(bad_index), 32'd0);
    for (int i = 0; i < NV; i++) rd(i);
    rd(7);

    // Write on the vsync_rise cycle joins that commit
    req0_valid = 1'b1; req0_index = 3'd0; req0_data = 12'h0AA;
    tick();
    m_shadow[0] = 12'h0AA;
    req0_index = 3'd4; req0_data = 12'hDEF;
    vsync = 1'b1;
    #1;
    chk("edge_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    m_shadow[4] = 12'hDEF;
    commit_tail(1'b0);
    tick();
    rd(4);
    rd(0);

    // Reset mid-commit clears everything, no late commit_done
    req0_valid = 1'b1; req0_index = 3'd1; req0_data = 12'h777;
    tick();
    req0_valid = 1'b0;
    vsync = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vsync = 1'b0;
    for (int i = 0; i < NV; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    chk("midrst_pending", 32'(pending), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("midrst_done", 32'(commit_done), 32'd0);
      tick();
    end
    for (int i = 0; i < NV; i++) rd(i);

    tick();
    tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
